bram_tdp: RTL and testbench
===========================

# bram_tdp

Single-clock true dual-port block RAM with per-byte write enables, selectable read-during-write behaviour, an optional output register stage and a sequencer that clears the array after reset. It replaces the plain two-clock byte RAM wherever the core needs word-wide scratch, register-file or cache-data storage. Write-write address collisions between the two ports are resolved deterministically and flagged.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 10, address bits
- RAM_SIZE, 1<<ADDR_WIDTH, number of words
- BYTES, DATA_WIDTH/8, byte lanes (derived)
- RDW_MODE, WRITE_FIRST, same-port read-during-write mode: WRITE_FIRST, READ_FIRST or NO_CHANGE
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
- CLEAR_ON_RESET, 1, 1 clears every word after reset
- CLEAR_VALUE, 0, word written by the clear sequencer

Ports (x = a, b):
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req_x  in  1  request strobe
- i_we_x  in  1  1 = write, 0 = read
- i_be_x  in  BYTES  byte-lane write enables
- i_addr_x  in  ADDR_WIDTH  word address
- i_data_x  in  DATA_WIDTH  write data
- o_data_x  out  DATA_WIDTH  read or returned data
- o_valid_x  out  1  o_data_x is valid this cycle
- o_busy  out  1  clear sequence in progress; requests ignored
- o_collision  out  1  one-cycle pulse on a write-write lane collision

## Operation
- Clear FSM states: CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET is 1, otherwise READY.
  - In CLEAR, a counter runs 0..RAM_SIZE-1 and writes CLEAR_VALUE to one word per cycle. The state moves to READY after the last word.
  - Reset asserted mid-clear restarts the counter at 0.
- While o_busy is 1, i_req_x is ignored: no write, no o_valid, no collision.
- Read (i_req_x=1, i_we_x=0): returns mem[addr].
- Write (i_we_x=1): writes only the lanes where i_be_x is set. Other lanes keep their old bytes.
- Same-port read-during-write, by RDW_MODE:
  - WRITE_FIRST: returns the merged new word and pulses o_valid.
  - READ_FIRST: returns the old word and pulses o_valid.
  - NO_CHANGE: o_data holds its last value and o_valid stays 0.
- A write with i_be_x=0 changes no memory and follows the same RDW rule.
- Cross-port, same address:
  - Both ports write: per lane, port A's byte wins where both enables are set. Non-overlapping lanes merge. o_collision pulses only if at least one lane overlaps.
  - One port reads while the other writes: the read returns the old word and no collision is flagged.
- o_data_x holds its value between valid cycles.

## Timing
- Reset values: o_data_x = 0, o_valid_x = 0, o_collision = 0, o_busy = CLEAR_ON_RESET.
- Clear sequence: o_busy falls exactly RAM_SIZE cycles after reset deasserts. The first request is accepted in the cycle o_busy reads 0.
- Latency: request at edge N gives o_valid/o_data at N+1 when OUT_REG=0, or at N+2 when OUT_REG=1.
- Both ports accept one request per cycle with full throughput. There is no backpressure.
- o_collision aligns with port A's o_valid timing (N+1 or N+2).
- A write is visible to any read issued in the following cycle on either port.
- Reset asserted mid-pipeline drops in-flight valids immediately. Memory contents are undefined unless cleared.

## Structure
- Shared package bram_pkg holds:
  - the rdw_mode_t enum (WRITE_FIRST, READ_FIRST, NO_CHANGE)
  - the clear FSM state enum
  - a byte-merge function (old, new, be) → word
- Sub-module bram_out_pipe (instantiated once per port) holds the data/valid output register stage, bypassed when OUT_REG=0.
- Memory array, write arbitration, collision detection and clear FSM live in bram_tdp.

## Test plan
- Clear: RAM_SIZE=16, CLEAR_VALUE=32'hA5A5A5A5. Reset, wait for o_busy low, read all 16 addresses → all return A5A5A5A5 with o_busy low after exactly 16 cycles. Pulse reset at counter 7 → o_busy stays high a further 16 cycles.
- Byte enables: write 32'h11223344 with be=4'b1111 to address 3, then 32'hAABBCCDD with be=4'b0101 → read returns 32'h11BB33DD.
- RDW modes: address 5 holds 32'h0. Port A writes 32'hDEADBEEF with be=4'b1111 → WRITE_FIRST returns DEADBEEF, READ_FIRST returns 0, NO_CHANGE gives o_valid=0 with o_data unchanged.
- Collision: same cycle, A writes 32'h000000AA be=4'b0001 and B writes 32'h0000BBBB be=4'b0011 to address 9 → mem = 32'h0000BBAA, o_collision pulses once. With B be=4'b0010 instead → no pulse.
- Cross read: A writes 32'h55 to address 2 (old value 32'h0) while B reads address 2 → B returns 0. B reads address 2 the next cycle → returns 32'h55.
- Latency: OUT_REG=1 back-to-back reads of addresses 0..3 → o_valid high for four consecutive cycles starting 2 cycles after the first request, data in order.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and helpers for the true dual-port block RAM.
package bram_pkg;

  // Same-port read-during-write behaviour.
  typedef enum logic [1:0] {
    WRITE_FIRST = 2'd0,
    READ_FIRST  = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_t;

  // Post-reset clear sequencer states.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_DW    = 1024;
  localparam int MAX_BYTES = MAX_DW / 8;

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]    old_w,
                                                   input logic [MAX_DW-1:0]    new_w,
                                                   input logic [MAX_BYTES-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_tdp_if.sv
// One RAM access port: request side driven by the master, response by the RAM.
interface bram_tdp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    req;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    valid;

  modport master (output req, we, be, addr, wdata, input rdata, valid);
  modport slave  (input req, we, be, addr, wdata, output rdata, valid);
endinterface

// File: rtl/bram_out_pipe.sv
// Optional output register for one RAM port; a straight wire when OUT_REG is 0.
module bram_out_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  if (OUT_REG != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] data_p2;
    logic                  vld_p2;

    // Stage 2: data only moves on a valid beat so o_data holds between beats.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        data_p2 <= '0;
        vld_p2  <= 1'b0;
      end else begin
        vld_p2 <= i_valid;
        if (i_valid) data_p2 <= i_data;
      end
    end

    assign o_data  = data_p2;
    assign o_valid = vld_p2;
  end else begin : g_byp
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst;
    assign o_data  = i_data;
    assign o_valid = i_valid;
  end

endmodule

// File: rtl/bram_tdp.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// deterministic write-write arbitration (port A wins per lane) and post-reset clear.
module bram_tdp
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    RAM_SIZE       = 1 << ADDR_WIDTH,
  parameter rdw_mode_t             RDW_MODE       = WRITE_FIRST,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  bram_tdp_if.slave port_a,
  bram_tdp_if.slave port_b,
  output logic      o_busy,
  output logic      o_collision
);

  localparam int BYTES = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] merge_w(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] new_w,
                                                    input logic [BYTES-1:0]      be);
    return DATA_WIDTH'(byte_merge(MAX_DW'(old_w), MAX_DW'(new_w), MAX_BYTES'(be)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

  clr_state_t            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  busy_q;

  logic                  acc_a, acc_b, wr_a, wr_b, same_addr, coll_now;
  logic [BYTES-1:0]      be_b_shared;
  logic [DATA_WIDTH-1:0] old_a, old_b, own_a, own_b, word_a;

  logic [DATA_WIDTH-1:0] data_a_p1, data_b_p1;
  logic                  vld_a_p1, vld_b_p1, coll_p1;

  // Clear sequencer: one word per cycle from 0 to RAM_SIZE-1, then READY.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      busy_q  <= (CLEAR_ON_RESET != 0);
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_WIDTH'(RAM_SIZE - 1)) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign o_busy = busy_q;

  // Request decode, old-word fetch and write-word arbitration.
  always_comb begin
    acc_a       = port_a.req && !busy_q;
    acc_b       = port_b.req && !busy_q;
    wr_a        = acc_a && port_a.we;
    wr_b        = acc_b && port_b.we;
    same_addr   = (port_a.addr == port_b.addr);
    old_a       = mem[port_a.addr];
    old_b       = mem[port_b.addr];
    own_a       = merge_w(old_a, port_a.wdata, port_a.be);
    own_b       = merge_w(old_b, port_b.wdata, port_b.be);
    be_b_shared = (wr_b && same_addr) ? port_b.be : '0;
    // B's lanes go in first so A overwrites any lane both ports enable.
    word_a      = merge_w(merge_w(old_a, port_b.wdata, be_b_shared), port_a.wdata, port_a.be);
    coll_now    = wr_a && wr_b && same_addr && (|(port_a.be & port_b.be));
  end

  // Array update: clear words while busy, else the arbitrated port writes.
  always_ff @(posedge i_clk) begin
    if (busy_q) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else begin
      if (wr_b && !(wr_a && same_addr)) mem[port_b.addr] <= own_b;
      if (wr_a) mem[port_a.addr] <= word_a;
    end
  end

  // Stage 1, port A: read data per RDW mode, collision flag aligned with A.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_a_p1 <= '0;
      vld_a_p1  <= 1'b0;
      coll_p1   <= 1'b0;
    end else begin
      vld_a_p1 <= acc_a && (!port_a.we || RDW_MODE != NO_CHANGE);
      coll_p1  <= coll_now;
      if (acc_a) begin
        if (!port_a.we || RDW_MODE == READ_FIRST) data_a_p1 <= old_a;
        else if (RDW_MODE == WRITE_FIRST)         data_a_p1 <= own_a;
      end
    end
  end

  // Stage 1, port B: read data per RDW mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_b_p1 <= '0;
      vld_b_p1  <= 1'b0;
    end else begin
      vld_b_p1 <= acc_b && (!port_b.we || RDW_MODE != NO_CHANGE);
      if (acc_b) begin
        if (!port_b.we || RDW_MODE == READ_FIRST) data_b_p1 <= old_b;
        else if (RDW_MODE == WRITE_FIRST)         data_b_p1 <= own_b;
      end
    end
  end

  bram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (data_a_p1),
    .i_valid (vld_a_p1),
    .o_data  (port_a.rdata),
    .o_valid (port_a.valid)
  );

  bram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (data_b_p1),
    .i_valid (vld_b_p1),
    .o_data  (port_b.rdata),
    .o_valid (port_b.valid)
  );

  if (OUT_REG != 0) begin : g_coll_reg
    logic coll_p2;

    // Stage 2: collision pulse follows port A's extra output stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) coll_p2 <= 1'b0;
      else       coll_p2 <= coll_p1;
    end

    assign o_collision = coll_p2;
  end else begin : g_coll_byp
    assign o_collision = coll_p1;
  end

endmodule

// File: tb/tb_bram_tdp.sv
// Directed bench: four RAM variants (WRITE_FIRST, READ_FIRST, NO_CHANGE, and
// WRITE_FIRST with output register) share one stimulus stream.
module tb_bram_tdp;
  import bram_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_a, we_a, req_b, we_b;
  logic [3:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wd_a, wd_b;

  logic [NDUT-1:0][DW-1:0] rd_a, rd_b;
  logic [NDUT-1:0]         vl_a, vl_b, busy, coll;

  for (genvar g = 0; g < NDUT; g++) begin : gd
    bram_tdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pa ();
    bram_tdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pb ();

    assign pa.req   = req_a;
    assign pa.we    = we_a;
    assign pa.be    = be_a;
    assign pa.addr  = addr_a;
    assign pa.wdata = wd_a;
    assign pb.req   = req_b;
    assign pb.we    = we_b;
    assign pb.be    = be_b;
    assign pb.addr  = addr_b;
    assign pb.wdata = wd_b;

    bram_tdp #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .RAM_SIZE       (16),
      .RDW_MODE       (g == 1 ? READ_FIRST : (g == 2 ? NO_CHANGE : WRITE_FIRST)),
      .OUT_REG        (g == 3 ? 1 : 0),
      .CLEAR_ON_RESET (1),
      .CLEAR_VALUE    (32'hA5A5A5A5)
    ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .port_a      (pa),
      .port_b      (pb),
      .o_busy      (busy[g]),
      .o_collision (coll[g])
    );

    assign rd_a[g] = pa.rdata;
    assign vl_a[g] = pa.valid;
    assign rd_b[g] = pb.rdata;
    assign vl_b[g] = pb.valid;
  end

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    req_a = 1'b1; we_a = we; addr_a = a; wd_a = d; be_a = be;
  endtask

  task automatic drv_b(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    req_b = 1'b1; we_b = we; addr_b = a; wd_b = d; be_b = be;
  endtask

  task automatic idle();
    req_a = 1'b0; we_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle();
    addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0; be_a = '0; be_b = '0;
    tick();
    tick();

    // Reset state
    chkb("rst_busy", busy[0], 1'b1);
    chkb("rst_busy_oreg", busy[3], 1'b1);
    chkb("rst_valid", vl_a[0], 1'b0);
    chk("rst_data", rd_a[0], 32'h0);
    chkb("rst_coll", coll[0], 1'b0);

    // Clear interrupted at counter 7 restarts from zero
    rst = 1'b0;
    repeat (7) tick();
    chkb("busy_mid_clear", busy[0], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy[0] && n < 100);
    chk("clear_cycles", 32'(n), 32'd16);
    chkb("busy_low_oreg", busy[3], 1'b0);

    // Every word holds the clear value; first read in the cycle busy reads 0
    for (int i = 0; i < 16; i++) begin
      drv_a(1'b0, AW'(i), 32'h0, 4'h0);
      tick();
      chkb("clr_rd_valid", vl_a[0], 1'b1);
      chk("clr_rd_data", rd_a[0], 32'hA5A5A5A5);
    end
    idle();
    tick();
    chkb("idle_valid", vl_a[0], 1'b0);
    chk("idle_hold", rd_a[0], 32'hA5A5A5A5);

    // Byte enables
    drv_a(1'b1, 4'd3, 32'h11223344, 4'b1111); tick();
    drv_a(1'b1, 4'd3, 32'hAABBCCDD, 4'b0101); tick();
    drv_a(1'b0, 4'd3, 32'h0, 4'b0000);        tick();
    chk("be_merge", rd_a[0], 32'h11BB33DD);

    // Read-during-write modes on address 5
    drv_a(1'b1, 4'd5, 32'h0, 4'b1111); tick();
    drv_a(1'b0, 4'd4, 32'h0, 4'b0000); tick();
    drv_a(1'b1, 4'd5, 32'hDEADBEEF, 4'b1111); tick();
    chk("wf_data", rd_a[0], 32'hDEADBEEF);
    chkb("wf_valid", vl_a[0], 1'b1);
    chk("rf_data", rd_a[1], 32'h0);
    chkb("rf_valid", vl_a[1], 1'b1);
    chkb("nc_valid", vl_a[2], 1'b0);
    chk("nc_hold", rd_a[2], 32'hA5A5A5A5);
    drv_a(1'b1, 4'd5, 32'h12345678, 4'b0000); tick();
    chk("be0_wf_data", rd_a[0], 32'hDEADBEEF);
    chkb("be0_nc_valid", vl_a[2], 1'b0);
    drv_a(1'b0, 4'd5, 32'h0, 4'b0000); tick();
    chk("be0_no_write", rd_a[0], 32'hDEADBEEF);
    chk("nc_read", rd_a[2], 32'hDEADBEEF);

    // Write-write collision on address 9
    drv_a(1'b1, 4'd9, 32'h0, 4'b1111); tick();
    drv_a(1'b1, 4'd9, 32'h000000AA, 4'b0001);
    drv_b(1'b1, 4'd9, 32'h0000BBBB, 4'b0011);
    tick();
    chkb("coll_pulse", coll[0], 1'b1);
    chkb("coll_oreg_early", coll[3], 1'b0);
    idle();
    drv_a(1'b0, 4'd9, 32'h0, 4'b0000);
    tick();
    chkb("coll_one_cycle", coll[0], 1'b0);
    chkb("coll_oreg_late", coll[3], 1'b1);
    chk("coll_merge", rd_a[0], 32'h0000BBAA);
    drv_a(1'b1, 4'd9, 32'h000000AA, 4'b0001);
    drv_b(1'b1, 4'd9, 32'h0000BBBB, 4'b0010);
    tick();
    chkb("no_overlap_coll", coll[0], 1'b0);

    // Cross-port read while the other port writes
    idle();
    drv_a(1'b1, 4'd2, 32'h0, 4'b1111); tick();
    drv_a(1'b1, 4'd2, 32'h00000055, 4'b1111);
    drv_b(1'b0, 4'd2, 32'h0, 4'b0000);
    tick();
    chk("xrd_old", rd_b[0], 32'h0);
    chkb("xrd_valid", vl_b[0], 1'b1);
    chkb("xrd_no_coll", coll[0], 1'b0);
    idle();
    drv_b(1'b0, 4'd2, 32'h0, 4'b0000);
    tick();
    chk("xrd_new", rd_b[0], 32'h00000055);

    // Output-register latency with back-to-back reads
    idle();
    drv_a(1'b1, 4'd0, 32'h00000100, 4'b1111); tick();
    drv_a(1'b1, 4'd1, 32'h00000101, 4'b1111); tick();
    idle(); tick(); tick();
    chkb("lat_quiet", vl_a[3], 1'b0);
    drv_a(1'b0, 4'd0, 32'h0, 4'b0000); tick();
    chkb("lat_n1_valid", vl_a[3], 1'b0);
    drv_a(1'b0, 4'd1, 32'h0, 4'b0000); tick();
    chkb("lat_v0", vl_a[3], 1'b1);
    chk("lat_d0", rd_a[3], 32'h00000100);
    drv_a(1'b0, 4'd2, 32'h0, 4'b0000); tick();
    chkb("lat_v1", vl_a[3], 1'b1);
    chk("lat_d1", rd_a[3], 32'h00000101);
    drv_a(1'b0, 4'd3, 32'h0, 4'b0000); tick();
    chkb("lat_v2", vl_a[3], 1'b1);
    chk("lat_d2", rd_a[3], 32'h00000055);
    idle(); tick();
    chkb("lat_v3", vl_a[3], 1'b1);
    chk("lat_d3", rd_a[3], 32'h11BB33DD);
    tick();
    chkb("lat_end_valid", vl_a[3], 1'b0);
    chk("lat_end_hold", rd_a[3], 32'h11BB33DD);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
